// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Frame sequencer wrapped around an external 8:1 mux. A word accepted on the
// upstream valid/ready port is parked on the mux data inputs, and the select
// lines are stepped once per accepted downstream beat, so the mux output y
// becomes an 8-beat serial stream.
//
// Handshake rules (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. Once ser_valid is raised it stays
// high, with ser_data/ser_last/mux_sel stable, until the beat is taken; only
// an abort or a reset withdraws it. in_ready is high only while idle, so a
// word offered during a frame is left with the producer.
module mux_sel_sequencer #(
    parameter bit MSB_FIRST   = 1'b0,
    parameter int IDLE_CYCLES = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic [7:0]       mux_i,
    output logic [2:0]       mux_sel,
    input  logic             mux_y,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Select value for the first beat; also where the select rests between frames.
    localparam logic [2:0] START_SEL = MSB_FIRST ? 3'd7 : 3'd0;
    // Adding 7 in 3 bits walks the select downwards.
    localparam logic [2:0] SEL_STEP  = MSB_FIRST ? 3'd7 : 3'd1;
    localparam bit         HAS_GAP   = (IDLE_CYCLES > 0);
    localparam logic [3:0] GAP_LAST  = HAS_GAP ? 4'(IDLE_CYCLES - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       mux_i_q, mux_i_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       beat_q, beat_d;
    logic [3:0]       gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and datapath registers; reset parks the select on the start index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mux_i_q <= 8'h00;
            sel_q   <= START_SEL;
            beat_q  <= 3'd0;
            gap_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mux_i_q <= mux_i_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and handshake outputs; abort outranks load and beat completion.
    always_comb begin
        state_d   = state_q;
        mux_i_d   = mux_i_q;
        sel_d     = sel_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                // An abort in the same cycle swallows the load.
                if (in_valid && !abort) begin
                    mux_i_d = in_data;
                    sel_d   = START_SEL;
                    beat_d  = 3'd0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = mux_y;
                ser_last  = (beat_q == 3'd7);
                if (abort) begin
                    // The beat on the wire may still be taken downstream,
                    // but the frame is not counted.
                    state_d = ST_IDLE;
                    sel_d   = START_SEL;
                    beat_d  = 3'd0;
                end else if (ser_ready) begin
                    if (beat_q == 3'd7) begin
                        cnt_d   = cnt_q + CNT_ONE;
                        sel_d   = START_SEL;
                        beat_d  = 3'd0;
                        gap_d   = 4'd0;
                        state_d = HAS_GAP ? ST_GAP : ST_IDLE;
                    end else begin
                        sel_d  = sel_q + SEL_STEP;
                        beat_d = beat_q + 3'd1;
                    end
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    sel_d   = START_SEL;
                    beat_d  = 3'd0;
                end else if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = START_SEL;
                beat_d  = 3'd0;
            end
        endcase
    end

    assign mux_i     = mux_i_q;
    assign mux_sel   = sel_q;
    assign busy      = (state_q != ST_IDLE);
    assign frame_cnt = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer. Two instances share all stimulus:
// u0 = LSB-first, no gap, 8-bit counter; u1 = MSB-first, 3 gap cycles,
// 2-bit counter. Each drives its own behavioural 8:1 mux.
module tb_mux_sel_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       abort     = 1'b0;
    logic       ser_ready = 1'b1;
    int         rmode     = 0;

    logic [7:0] mux_i_w [2];
    logic [2:0] sel_w   [2];
    logic       y_w     [2];
    logic       rdy_w   [2];
    logic       sv_w    [2];
    logic       sd_w    [2];
    logic       sl_w    [2];
    logic       busy_w  [2];
    logic [1:0] st_w    [2];
    logic [7:0] fc0;
    logic [1:0] fc1;

    assign y_w[0] = mux_i_w[0][sel_w[0]];
    assign y_w[1] = mux_i_w[1][sel_w[1]];

    mux_sel_sequencer #(.MSB_FIRST(1'b0), .IDLE_CYCLES(0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_w[0]), .abort(abort), .mux_i(mux_i_w[0]), .mux_sel(sel_w[0]),
        .mux_y(y_w[0]), .ser_valid(sv_w[0]), .ser_data(sd_w[0]), .ser_last(sl_w[0]),
        .ser_ready(ser_ready), .busy(busy_w[0]), .frame_cnt(fc0), .state_dbg(st_w[0])
    );

    mux_sel_sequencer #(.MSB_FIRST(1'b1), .IDLE_CYCLES(3), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_w[1]), .abort(abort), .mux_i(mux_i_w[1]), .mux_sel(sel_w[1]),
        .mux_y(y_w[1]), .ser_valid(sv_w[1]), .ser_data(sd_w[1]), .ser_last(sl_w[1]),
        .ser_ready(ser_ready), .busy(busy_w[1]), .frame_cnt(fc1), .state_dbg(st_w[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    function automatic int p_msb(input int d); return d;            endfunction
    function automatic int p_idl(input int d); return (d != 0) ? 3 : 0; endfunction
    function automatic int p_cmask(input int d); return (d != 0) ? 3 : 255; endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a word, 1 streaming, 2 dead time after a frame
    int         m_ph   [2] = '{0, 0};
    int         m_beat [2] = '{0, 0};
    int         m_gap  [2] = '{0, 0};
    int         m_cnt  [2] = '{0, 0};
    int         m_acc  [2] = '{0, 0};
    logic [7:0] m_word [2] = '{8'h00, 8'h00};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_ph[d] <= 0; m_beat[d] <= 0; m_gap[d] <= 0;
                m_cnt[d] <= 0; m_word[d] <= 8'h00;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_ph[d] == 0) begin
                    if (in_valid && !abort) begin
                        m_word[d] <= in_data;
                        m_beat[d] <= 0;
                        m_ph[d]   <= 1;
                        m_acc[d]  <= m_acc[d] + 1;
                    end
                end else if (m_ph[d] == 1) begin
                    if (abort) begin
                        m_ph[d] <= 0; m_beat[d] <= 0;
                    end else if (ser_ready) begin
                        if (m_beat[d] == 7) begin
                            m_cnt[d]  <= m_cnt[d] + 1;
                            m_beat[d] <= 0;
                            if (p_idl(d) > 0) begin
                                m_ph[d] <= 2; m_gap[d] <= p_idl(d);
                            end else begin
                                m_ph[d] <= 0;
                            end
                        end else begin
                            m_beat[d] <= m_beat[d] + 1;
                        end
                    end
                end else begin
                    if (abort) m_ph[d] <= 0;
                    else begin
                        m_gap[d] <= m_gap[d] - 1;
                        if (m_gap[d] == 1) m_ph[d] <= 0;
                    end
                end
            end
        end
    end

    // ---------------- compare + observation ----------------
    logic [7:0] rec [2];
    int         ob [2]        = '{0, 0};
    int         last_seen [2] = '{0, 0};
    int         gap_obs [2]   = '{0, 0};
    int         xfer [2]      = '{0, 0};
    logic [7:0] done_q0 [$];
    logic [7:0] done_q1 [$];
    logic [1:0] fc_hist [$];
    logic [1:0] fc1_prev = 2'd0;
    int         se_v;
    logic [2:0] pos_v;
    logic [31:0] fc_act;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                se_v = (m_ph[d] == 1) ? ((p_msb(d) != 0) ? 7 - m_beat[d] : m_beat[d])
                                      : ((p_msb(d) != 0) ? 7 : 0);
                fc_act = (d == 0) ? 32'(fc0) : 32'(fc1);
                chk("in_ready",  d, 32'(rdy_w[d]),   32'(m_ph[d] == 0));
                chk("busy",      d, 32'(busy_w[d]),  32'(m_ph[d] != 0));
                chk("ser_valid", d, 32'(sv_w[d]),    32'(m_ph[d] == 1));
                chk("ser_last",  d, 32'(sl_w[d]),    32'(m_ph[d] == 1 && m_beat[d] == 7));
                chk("mux_sel",   d, 32'(sel_w[d]),   32'(se_v));
                chk("ser_data",  d, 32'(sd_w[d]),    32'((m_ph[d] == 1) ? m_word[d][se_v] : 1'b0));
                chk("mux_i",     d, 32'(mux_i_w[d]), 32'(m_word[d]));
                chk("frame_cnt", d, fc_act,          32'(m_cnt[d] & p_cmask(d)));

                if (busy_w[d] && !sv_w[d]) gap_obs[d]++;
                if (sv_w[d] && ser_ready) begin
                    xfer[d]++;
                    pos_v = (p_msb(d) != 0) ? 3'(7 - ob[d]) : 3'(ob[d]);
                    rec[d][pos_v] = sd_w[d];
                    if (abort) ob[d] = 0;
                    else if (sl_w[d]) begin
                        last_seen[d]++;
                        if (d == 0) done_q0.push_back(rec[d]);
                        else        done_q1.push_back(rec[d]);
                        ob[d] = 0;
                    end else ob[d] = ob[d] + 1;
                end else if (abort && sv_w[d]) begin
                    ob[d] = 0;
                end
            end
            if (fc1 !== fc1_prev) begin
                fc_hist.push_back(fc1);
                fc1_prev = fc1;
            end
        end else begin
            ob[0] = 0; ob[1] = 0;
        end
    end

    // ser_ready pattern: 1 = toggle every cycle, 2 = random, 0 = held by driver
    always @(posedge clk) begin
        #1;
        if (rmode == 1) ser_ready = ~ser_ready;
        else if (rmode == 2) ser_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_ph[0] != 0 || m_ph[1] != 0) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", budget);
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        wait_idle(200);
        in_valid = 1'b1; in_data = w;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic wait_beat(input int b);
        int n = 0;
        while (!(m_ph[0] == 1 && m_beat[0] == b) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL wait_beat: got no beat %0d expected one", b);
        end
    endtask

    task automatic clear_obs();
        done_q0.delete(); done_q1.delete();
        for (int d = 0; d < 2; d++) begin gap_obs[d] = 0; xfer[d] = 0; end
    endtask

    // ---------------- stimulus ----------------
    int exp_seq [4] = '{1, 2, 3, 0};
    int base_acc, ls0, ls1;
    logic [7:0] rw;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy",      d, 32'(busy_w[d]),  32'd0);
            chk("rst_ser_valid", d, 32'(sv_w[d]),    32'd0);
            chk("rst_ser_last",  d, 32'(sl_w[d]),    32'd0);
            chk("rst_mux_i",     d, 32'(mux_i_w[d]), 32'h00);
            chk("rst_mux_sel",   d, 32'(sel_w[d]),   (d != 0) ? 32'd7 : 32'd0);
        end
        chk("rst_frame_cnt", 0, 32'(fc0), 32'd0);
        chk("rst_frame_cnt", 1, 32'(fc1), 32'd0);
        rst_n = 1'b1;

        // A5 at full rate
        clear_obs();
        send_word(8'hA5);
        wait_idle(100);
        chk("a5_frames", 0, 32'(done_q0.size()), 32'd1);
        chk("a5_frames", 1, 32'(done_q1.size()), 32'd1);
        if (done_q0.size() > 0) chk("a5_word", 0, 32'(done_q0[0]), 32'hA5);
        if (done_q1.size() > 0) chk("a5_word", 1, 32'(done_q1[0]), 32'hA5);
        chk("a5_cnt", 0, 32'(fc0), 32'd1);

        // 81 with ser_ready toggling
        clear_obs();
        rmode = 1;
        send_word(8'h81);
        wait_idle(200);
        rmode = 0; ser_ready = 1'b1;
        chk("x81_xfers", 0, 32'(xfer[0]), 32'd8);
        chk("x81_xfers", 1, 32'(xfer[1]), 32'd8);
        if (done_q0.size() > 0) chk("x81_word", 0, 32'(done_q0[0]), 32'h81);
        if (done_q1.size() > 0) chk("x81_word", 1, 32'(done_q1[0]), 32'h81);
        chk("x81_cnt", 0, 32'(fc0), 32'd2);

        // FF then 00 with in_valid held; u1 shows the dead cycles
        clear_obs();
        base_acc = m_acc[1];
        in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk); #1;
        in_data = 8'h00;
        for (int n = 0; n < 100 && m_acc[1] < base_acc + 2; n++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle(100);
        chk("ff00_frames", 1, 32'(done_q1.size()), 32'd2);
        if (done_q1.size() == 2) begin
            chk("ff00_first",  1, 32'(done_q1[0]), 32'hFF);
            chk("ff00_second", 1, 32'(done_q1[1]), 32'h00);
        end
        if (done_q0.size() > 0) chk("ff00_first", 0, 32'(done_q0[0]), 32'hFF);
        chk("ff00_gap_cycles", 1, 32'(gap_obs[1]), 32'd6);
        chk("ff00_gap_cycles", 0, 32'(gap_obs[0]), 32'd0);
        chk("wrap_len", 1, 32'(fc_hist.size()), 32'd4);
        for (int i = 0; i < 4 && i < fc_hist.size(); i++)
            chk("wrap_seq", 1, 32'(fc_hist[i]), 32'(exp_seq[i]));

        // abort at beat 4 of 3C, then C3
        clear_obs();
        ls0 = last_seen[0]; ls1 = last_seen[1];
        send_word(8'h3C);
        wait_beat(4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("abort_busy", 1, 32'(busy_w[1]), 32'd0);
        chk("abort_no_last", 0, 32'(last_seen[0]), 32'(ls0));
        chk("abort_no_last", 1, 32'(last_seen[1]), 32'(ls1));
        chk("abort_cnt", 0, 32'(fc0), 32'd4);
        send_word(8'hC3);
        wait_idle(100);
        chk("c3_frames", 0, 32'(done_q0.size()), 32'd1);
        if (done_q0.size() > 0) chk("c3_word", 0, 32'(done_q0[0]), 32'hC3);
        if (done_q1.size() > 0) chk("c3_word", 1, 32'(done_q1[0]), 32'hC3);

        // asynchronous reset at beat 5
        ls0 = last_seen[0];
        rw = 8'($urandom);
        send_word(rw);
        wait_beat(5);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("mid_rst_busy",      d, 32'(busy_w[d]),  32'd0);
            chk("mid_rst_ser_valid", d, 32'(sv_w[d]),    32'd0);
            chk("mid_rst_ser_last",  d, 32'(sl_w[d]),    32'd0);
            chk("mid_rst_ser_data",  d, 32'(sd_w[d]),    32'd0);
            chk("mid_rst_mux_i",     d, 32'(mux_i_w[d]), 32'h00);
            chk("mid_rst_mux_sel",   d, 32'(sel_w[d]),   (d != 0) ? 32'd7 : 32'd0);
        end
        chk("mid_rst_cnt", 0, 32'(fc0), 32'd0);
        chk("mid_rst_cnt", 1, 32'(fc1), 32'd0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 0, 32'(rdy_w[0]), 32'd1);
        chk("post_rst_in_ready", 1, 32'(rdy_w[1]), 32'd1);
        chk("post_rst_no_last", 0, 32'(last_seen[0]), 32'(ls0));
        @(posedge clk); #1;

        // random traffic
        rmode = 2;
        for (int n = 0; n < 600; n++) begin
            in_valid = ($urandom_range(0, 1) != 0);
            in_data  = 8'($urandom);
            abort    = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; abort = 1'b0;
        rmode = 0; ser_ready = 1'b1;
        wait_idle(100);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Frame sequencer that sits directly around the 8:1 gate-level mux. It drives the mux data inputs (i0..i7) and selects (s2,s1,s0). It captures the mux output y and turns an 8-bit parallel word into an 8-beat serial stream with a valid/ready handshake. The upstream producer loads words through a valid/ready port; the downstream consumer receives one bit per accepted beat.

Parameters:
MSB_FIRST, 0, 0 = select order 0→7 (i0 first); 1 = select order 7→0 (i7 first)
IDLE_CYCLES, 0, extra dead cycles in GAP after each completed frame (0..15)
CNT_W, 8, width of completed-frame counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_data  input  8  upstream parallel word; bit k goes to mux input ik
in_ready  output  1  block can accept a word
abort  input  1  synchronous frame abort
mux_i  output  8  to mux i7..i0 (bit k → ik)
mux_sel  output  3  to mux {s2,s1,s0}
mux_y  input  1  mux output y (combinational from mux_i/mux_sel)
ser_valid  output  1  serial beat valid
ser_data  output  1  serial bit
ser_last  output  1  high on 8th beat of frame
ser_ready  input  1  downstream accepts beat
busy  output  1  state != IDLE
frame_cnt  output  CNT_W  completed frames, wraps

Behaviour:
- Reset (rst_n=0, async): state=IDLE; mux_i=8'h00; mux_sel=3'd0 (3'd7 if MSB_FIRST); beat counter=0; gap counter=0; frame_cnt=0; ser_valid=0, ser_last=0, busy=0; in_ready=1 once rst_n deasserts.
- States: IDLE, SHIFT, GAP.
- IDLE: in_ready=1, ser_valid=0.
  - in_valid&in_ready at an edge: mux_i<=in_data, mux_sel<=start index, beat<=0, state<=SHIFT.
- SHIFT: in_ready=0, ser_valid=1, ser_data=mux_y (combinational pass-through). ser_last=(beat==7).
  - Beat transfers on ser_valid&ser_ready: mux_sel<=mux_sel+1 (−1 if MSB_FIRST, 3-bit wrap), beat<=beat+1.
  - Transfer with beat==7: frame_cnt<=frame_cnt+1 (wraps 2^CNT_W−1→0); mux_sel<=start index; state<=GAP if IDLE_CYCLES>0, else IDLE.
  - ser_ready=0: mux_i, mux_sel, beat, ser_valid and ser_data held stable (AXI-style; valid never drops without a transfer).
- GAP: in_ready=0, ser_valid=0; count IDLE_CYCLES cycles, then IDLE.
- Latency: first beat is valid on the cycle after word acceptance.
  - Max throughput is 8 beats + 1 IDLE cycle + IDLE_CYCLES per frame. No back-to-back load during the last beat.
- Outside SHIFT: ser_data=0 and ser_last=0.
- abort=1 at an edge in SHIFT or GAP: state<=IDLE, mux_sel<=start index, beat<=0; frame_cnt unchanged.
  - Abort takes priority over a simultaneous beat-7 transfer: the beat transfers downstream, but frame_cnt does not increment.
  - abort in IDLE: no effect, and it also blocks a same-cycle load (load ignored).
- in_valid while busy: ignored; the word is not consumed (in_ready=0).
- in_data changes after acceptance: no effect; mux_i holds the latched word for the whole frame.
- Reset mid-frame: immediate return to reset values; the partial frame is lost and no ser_last is issued.
- Start index = 0 when MSB_FIRST=0; 7 when MSB_FIRST=1.

Test Plan:
- Reset, then load in_data=8'hA5, MSB_FIRST=0, ser_ready=1 → ser_data beats 1,0,1,0,0,1,0,1; mux_sel 0..7; ser_last only on beat 8; frame_cnt=1; in_ready back to 1 one cycle later.
- MSB_FIRST=1, in_data=8'h81, ser_ready toggled every other cycle → beats 1,0,0,0,0,0,0,1; mux_sel 7→0; ser_data/mux_sel stable while ser_ready=0; exactly 8 transfers.
- IDLE_CYCLES=3, two words 8'hFF then 8'h00 with in_valid held → 3 GAP cycles with in_ready=0 between frames; second frame all zeros; frame_cnt=2.
- abort asserted at beat 4 of 8'h3C → IDLE next cycle; no ser_last; frame_cnt unchanged; next word 8'hC3 streams correctly from mux_sel=0.
- rst_n pulsed low mid-frame (beat 5) → all outputs take reset values asynchronously; after release, in_ready=1 and frame_cnt=0.
- CNT_W=2, four full frames → frame_cnt sequence 1,2,3,0 (wrap).
